// File: rtl/multi_int_controller.sv
// Multi-channel interrupt controller: synchronised edge/level capture, pending latch,
// fixed-priority encoder and request/ack FSM. Optional overrun flags: MULTI_INT_OVERRUN_EN.
module multi_int_controller #(
  parameter int NUM_INT     = 8,
  parameter int VEC_W       = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_INT-1:0] int_in,
  input  logic [NUM_INT-1:0] int_en,
  input  logic [NUM_INT-1:0] pos_en,
  input  logic [NUM_INT-1:0] neg_en,
  input  logic [NUM_INT-1:0] level_en,
  input  logic               clr_wr,
  input  logic [NUM_INT-1:0] clr_mask,
  input  logic               int_ack,
  output logic               int_out,
  output logic [VEC_W-1:0]   int_vec,
  output logic [NUM_INT-1:0] int_pending
`ifdef MULTI_INT_OVERRUN_EN
  ,
  output logic [NUM_INT-1:0] int_overrun
`endif
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ASSERT = 1'b1} state_e;

  // Lowest set index wins.
  function automatic logic [VEC_W-1:0] prio_enc(input logic [NUM_INT-1:0] req);
    prio_enc = {VEC_W{1'b0}};
    for (int i = NUM_INT - 1; i >= 0; i--) begin
      if (req[i]) prio_enc = VEC_W'(i);
    end
  endfunction

  logic [SYNC_STAGES-1:0][NUM_INT-1:0] sync_q, sync_d;
  logic [NUM_INT-1:0] hist_q, pending_q, pending_d;
  logic [NUM_INT-1:0] sync_s, rise_s, fall_s, edge_s, sel_s, clr_s, sw_clr_s, req_s;
  logic               req_hit_s;
  state_e             state_q;
  logic               int_out_q;
  logic [VEC_W-1:0]   int_vec_q;

  always_comb begin
    sync_d    = {SYNC_STAGES{{NUM_INT{1'b0}}}};
    sync_d[0] = int_in;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
    sync_s = sync_q[SYNC_STAGES-1];
    rise_s = sync_s & ~hist_q & pos_en;
    fall_s = ~sync_s & hist_q & neg_en;
    edge_s = (rise_s | fall_s) & ~level_en;
    for (int i = 0; i < NUM_INT; i++) begin
      sel_s[i] = (int_vec_q == VEC_W'(i));
    end
    sw_clr_s  = clr_mask & {NUM_INT{clr_wr}};
    clr_s     = sw_clr_s | (sel_s & {NUM_INT{int_ack && (state_q == ST_ASSERT)}});
    // A new edge wins over any clear in the same cycle so it cannot be lost.
    pending_d = (level_en & sync_s) | (~level_en & (edge_s | (pending_q & ~clr_s)));
    req_s     = pending_q & int_en;
    req_hit_s = |(req_s & sel_s);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= {SYNC_STAGES{{NUM_INT{1'b0}}}};
      hist_q    <= {NUM_INT{1'b0}};
      pending_q <= {NUM_INT{1'b0}};
    end else begin
      sync_q    <= sync_d;
      hist_q    <= sync_s;
      pending_q <= pending_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      int_out_q <= 1'b0;
      int_vec_q <= {VEC_W{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_s != {NUM_INT{1'b0}}) begin
            state_q   <= ST_ASSERT;
            int_out_q <= 1'b1;
            int_vec_q <= prio_enc(req_s);
          end else begin
            int_out_q <= 1'b0;
          end
        end
        ST_ASSERT: begin
          // Returning through IDLE guarantees a low cycle before the next request.
          if (int_ack || !req_hit_s) begin
            state_q   <= ST_IDLE;
            int_out_q <= 1'b0;
          end else begin
            int_out_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          int_out_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef MULTI_INT_OVERRUN_EN
  logic [NUM_INT-1:0] overrun_q, overrun_d;

  always_comb begin
    overrun_d = (edge_s & pending_q) | (overrun_q & ~sw_clr_s);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q <= {NUM_INT{1'b0}};
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign int_overrun = overrun_q;
`endif

  assign int_out     = int_out_q;
  assign int_vec     = int_vec_q;
  assign int_pending = pending_q;

endmodule

// File: tb/tb_multi_int_controller.sv
// Bench for multi_int_controller: vector table, directed corner sequences and a
// randomized run checked against a delay-line/queue reference model.
module tb_multi_int_controller;

  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] int_in, int_en, pos_en, neg_en, level_en, clr_mask;
  logic       clr_wr, int_ack;
  logic       int_out;
  logic [2:0] int_vec;
  logic [7:0] int_pending;
`ifdef MULTI_INT_OVERRUN_EN
  logic [7:0] int_overrun;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multi_int_controller #(.NUM_INT(8), .VEC_W(3), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .int_in(int_in), .int_en(int_en), .pos_en(pos_en),
    .neg_en(neg_en), .level_en(level_en), .clr_wr(clr_wr), .clr_mask(clr_mask),
    .int_ack(int_ack), .int_out(int_out), .int_vec(int_vec), .int_pending(int_pending)
`ifdef MULTI_INT_OVERRUN_EN
    , .int_overrun(int_overrun)
`endif
  );

  typedef struct {
    logic [7:0] init_in;
    logic [7:0] new_in;
    logic [7:0] en;
    logic [7:0] pos;
    logic [7:0] neg;
    logic [7:0] exp_pend;
    logic       exp_out;
    logic [2:0] exp_vec;
  } vec_t;

  vec_t vecs [10];

  // Reference model state: sampled-input history (newest first) and request bookkeeping.
  logic [7:0] m_hist [$];
  logic [7:0] m_pend, m_ov;
  bit         m_busy;
  int         m_vec;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic model_reset();
    m_hist = {};
    for (int i = 0; i <= SYNC; i++) m_hist.push_back(8'h00);
    m_pend = 8'h00;
    m_ov   = 8'h00;
    m_busy = 1'b0;
    m_vec  = 0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    int_in = 8'h00; int_en = 8'h00; pos_en = 8'h00; neg_en = 8'h00;
    level_en = 8'h00; clr_mask = 8'h00; clr_wr = 1'b0; int_ack = 1'b0;
    ticks(2);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic ack_pulse();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  // One clock edge of the specified behaviour, using the inputs currently driven.
  task automatic model_step();
    logic [7:0] s, h, req, np, nov;
    bit ev, clr;
    s   = m_hist[SYNC-1];
    h   = m_hist[SYNC];
    req = m_pend & int_en;
    for (int i = 0; i < 8; i++) begin
      ev  = ((s[i] && !h[i] && pos_en[i]) || (!s[i] && h[i] && neg_en[i])) && !level_en[i];
      clr = (clr_wr && clr_mask[i]) || (m_busy && int_ack && (m_vec == i));
      if (level_en[i]) np[i] = s[i];
      else             np[i] = ev || (m_pend[i] && !clr);
      nov[i] = (ev && m_pend[i]) || (m_ov[i] && !(clr_wr && clr_mask[i]));
    end
    if (!m_busy) begin
      if (req != 8'h00) begin
        for (int i = 7; i >= 0; i--) if (req[i]) m_vec = i;
        m_busy = 1'b1;
      end
    end else if (int_ack || !req[m_vec]) begin
      m_busy = 1'b0;
    end
    m_pend = np;
    m_ov   = nov;
    m_hist.push_front(int_in);
    void'(m_hist.pop_back());
  endtask

  initial begin
    vecs[0] = '{8'h00, 8'h04, 8'h04, 8'h04, 8'h00, 8'h04, 1'b1, 3'd2};
    vecs[1] = '{8'h00, 8'h04, 8'h04, 8'h00, 8'h04, 8'h00, 1'b0, 3'd0};
    vecs[2] = '{8'hFF, 8'hBF, 8'hFF, 8'h00, 8'h40, 8'h40, 1'b1, 3'd6};
    vecs[3] = '{8'h00, 8'h22, 8'hFF, 8'hFF, 8'h00, 8'h22, 1'b1, 3'd1};
    vecs[4] = '{8'h00, 8'h08, 8'h00, 8'h08, 8'h00, 8'h08, 1'b0, 3'd0};
    vecs[5] = '{8'h00, 8'h81, 8'h80, 8'hFF, 8'h00, 8'h81, 1'b1, 3'd7};
    vecs[6] = '{8'h0F, 8'hF0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1, 3'd0};
    vecs[7] = '{8'h0F, 8'hF0, 8'hFF, 8'hF0, 8'h0C, 8'hFC, 1'b1, 3'd2};
    vecs[8] = '{8'h00, 8'h01, 8'h01, 8'h01, 8'h00, 8'h01, 1'b1, 3'd0};
    vecs[9] = '{8'h55, 8'hAA, 8'hAA, 8'hAA, 8'h00, 8'hAA, 1'b1, 3'd1};

    apply_reset();
    chk("reset_out", int_out, 1'b0);
    chk("reset_vec", int_vec, 3'd0);
    chk("reset_pend", int_pending, 8'h00);

    // Vector table: single transition, pending at edge 3, request at edge 4.
    for (int v = 0; v < 10; v++) begin
      apply_reset();
      int_in = vecs[v].init_in;
      ticks(4);
      int_en = vecs[v].en; pos_en = vecs[v].pos; neg_en = vecs[v].neg;
      int_in = vecs[v].new_in;
      ticks(2);
      chk($sformatf("v%0d_pend_e2", v), int_pending, 8'h00);
      tick();
      chk($sformatf("v%0d_pend_e3", v), int_pending, vecs[v].exp_pend);
      chk($sformatf("v%0d_out_e3", v), int_out, 1'b0);
      tick();
      chk($sformatf("v%0d_out_e4", v), int_out, vecs[v].exp_out);
      chk($sformatf("v%0d_vec_e4", v), int_vec, vecs[v].exp_vec);
    end

    // Single channel request and ack.
    apply_reset();
    int_en = 8'h04; pos_en = 8'h04;
    tick();
    int_in = 8'h04;
    ticks(4);
    chk("s1_out", int_out, 1'b1);
    chk("s1_vec", int_vec, 3'd2);
    ack_pulse();
    chk("s1_ack_pend", int_pending, 8'h00);
    chk("s1_ack_out", int_out, 1'b0);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    chk("s1_idle_ack_out", int_out, 1'b0);
    chk("s1_idle_ack_vec", int_vec, 3'd2);

    // Two simultaneous edges are served lowest index first with a gap between.
    apply_reset();
    int_en = 8'hFF; pos_en = 8'hFF;
    int_in = 8'h22;
    ticks(4);
    chk("s2_vec1", int_vec, 3'd1);
    chk("s2_out1", int_out, 1'b1);
    ack_pulse();
    chk("s2_gap", int_out, 1'b0);
    chk("s2_pend_mid", int_pending, 8'h20);
    tick();
    chk("s2_out2", int_out, 1'b1);
    chk("s2_vec5", int_vec, 3'd5);
    ack_pulse();
    chk("s2_pend_end", int_pending, 8'h00);

    // Level channel re-requests after ack until the source drops.
    apply_reset();
    level_en = 8'h08; int_en = 8'h08; int_in = 8'h08;
    ticks(4);
    chk("s3_out", int_out, 1'b1);
    chk("s3_vec", int_vec, 3'd3);
    ack_pulse();
    chk("s3_gap", int_out, 1'b0);
    chk("s3_pend_kept", int_pending, 8'h08);
    tick();
    chk("s3_rereq", int_out, 1'b1);
    int_in = 8'h00;
    ticks(SYNC + 2);
    chk("s3_drop_out", int_out, 1'b0);
    chk("s3_drop_pend", int_pending, 8'h00);

    // Masking the active channel withdraws the request without losing pending.
    apply_reset();
    int_en = 8'h01; pos_en = 8'h01; int_in = 8'h01;
    ticks(4);
    chk("s4_out", int_out, 1'b1);
    int_en = 8'h00;
    tick();
    chk("s4_mask_out", int_out, 1'b0);
    chk("s4_mask_pend", int_pending, 8'h01);
    int_en = 8'h01;
    tick();
    chk("s4_resume_out", int_out, 1'b1);
    chk("s4_resume_vec", int_vec, 3'd0);

    // New edge on ch4 coincides with its ack.
    apply_reset();
    int_en = 8'h10; pos_en = 8'h10; int_in = 8'h10;
    ticks(4);
    chk("s5_out", int_out, 1'b1);
`ifdef MULTI_INT_OVERRUN_EN
    chk("s5_ovr_pre", int_overrun, 8'h00);
`endif
    int_in = 8'h00;
    tick();
    int_in = 8'h10;
    ticks(2);
    ack_pulse();
    chk("s5_pend_kept", int_pending, 8'h10);
    chk("s5_gap", int_out, 1'b0);
`ifdef MULTI_INT_OVERRUN_EN
    chk("s5_ovr_set", int_overrun, 8'h10);
`endif
    tick();
    chk("s5_reassert", int_out, 1'b1);
    chk("s5_vec", int_vec, 3'd4);
    clr_wr = 1'b1; clr_mask = 8'h10;
    tick();
    clr_wr = 1'b0; clr_mask = 8'h00;
    chk("s5_clr_pend", int_pending, 8'h00);
`ifdef MULTI_INT_OVERRUN_EN
    chk("s5_ovr_clr", int_overrun, 8'h00);
`endif
    tick();
    chk("s5_clr_out", int_out, 1'b0);

    // Asynchronous reset while requesting.
    apply_reset();
    int_en = 8'hFF; pos_en = 8'hFF; int_in = 8'h40;
    ticks(4);
    chk("s6_pre_out", int_out, 1'b1);
    chk("s6_pre_vec", int_vec, 3'd6);
    #2 rst_n = 1'b0;
    #1;
    chk("s6_rst_out", int_out, 1'b0);
    chk("s6_rst_vec", int_vec, 3'd0);
    chk("s6_rst_pend", int_pending, 8'h00);
    tick();

    // Randomized run against the reference model.
    apply_reset();
    for (int seg = 0; seg < 4; seg++) begin
      int_en = 8'($urandom); pos_en = 8'($urandom);
      neg_en = 8'($urandom); level_en = 8'($urandom) & 8'($urandom);
      for (int c = 0; c < 150; c++) begin
        int_in  = int_in ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
        int_ack = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
        clr_wr  = ($urandom_range(0, 15) == 0);
        clr_mask = 8'($urandom);
        model_step();
        tick();
        chk("rnd_out", int_out, m_busy);
        chk("rnd_vec", int_vec, 32'(m_vec));
        chk("rnd_pend", int_pending, m_pend);
`ifdef MULTI_INT_OVERRUN_EN
        chk("rnd_ovr", int_overrun, m_ov);
`endif
      end
    end
    int_ack = 1'b0; clr_wr = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
